// File: rtl/countdown_scan_display.sv
// N-digit BCD countdown timer with expiry flag, driving a time-multiplexed
// active-low 7-segment display with leading-zero blanking and an expiry blink.
module countdown_scan_display #(
  parameter int DIGITS   = 3,
  parameter int TICK_DIV = 100000000,
  parameter int SCAN_DIV = 100000
) (
  input  logic                  orig_clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_bcd,
  input  logic                  run,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  tick,
  output logic                  expired
);

  localparam int CW = 4 * DIGITS;
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [TW-1:0] PRESC_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] PRESC_HALF = TW'(TICK_DIV / 2);
  localparam logic [TW-1:0] PRESC_ONE  = TW'(1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SCAN_ONE   = SW'(1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);
  localparam logic [6:0]    SEG_BLANK  = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAUSE   = 2'd1,
    S_RUN     = 2'd2,
    S_EXPIRED = 2'd3
  } state_e;

  function automatic logic [CW-1:0] clamp_bcd(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Borrow ripples up from digit 0; a zero value is returned unchanged.
  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = (v != {CW{1'b0}});
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     load_val_s, dec_s;
  logic [TW-1:0]     presc_q, presc_d;
  logic              presc_wrap_s;
  logic [SW-1:0]     scan_q, scan_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              tick_d;
  logic [3:0]        digit_s;
  logic              hi_nonzero_s, lz_s, blink_off_s;
  logic [6:0]        seg_d, seg_q;
  logic [DIGITS-1:0] an_d, an_q;
  logic              tick_q, expired_q;

  assign load_val_s   = clamp_bcd(load_bcd);
  assign dec_s        = bcd_dec(count_q);
  assign presc_wrap_s = (presc_q == PRESC_LAST);

  // Countdown FSM next state: load wins over any coincident wrap or run change.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (load) begin
      count_d = load_val_s;
      presc_d = {TW{1'b0}};
      if (load_val_s == {CW{1'b0}}) begin
        state_d = S_EXPIRED;
      end else begin
        state_d = S_PAUSE;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_PAUSE, S_RUN: begin
          if (run) begin
            if (presc_wrap_s) begin
              presc_d = {TW{1'b0}};
              count_d = dec_s;
              tick_d  = 1'b1;
              if (dec_s == {CW{1'b0}}) begin
                state_d = S_EXPIRED;
              end else begin
                state_d = S_RUN;
              end
            end else begin
              presc_d = presc_q + PRESC_ONE;
              state_d = S_RUN;
            end
          end else begin
            state_d = S_PAUSE;
          end
        end
        S_EXPIRED: begin
          // Prescaler keeps running here purely to time the blink.
          if (presc_wrap_s) begin
            presc_d = {TW{1'b0}};
          end else begin
            presc_d = presc_q + PRESC_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Digit scan counter and index, free-running outside reset.
  always_comb begin
    scan_d = scan_q;
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = {SW{1'b0}};
      if (idx_q == IDX_LAST) begin
        idx_d = {IW{1'b0}};
      end else begin
        idx_d = idx_q + IDX_ONE;
      end
    end else begin
      scan_d = scan_q + SCAN_ONE;
    end
  end

  // Segment/anode decode from next-state values so outputs track the count.
  always_comb begin
    digit_s      = 4'd0;
    hi_nonzero_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        digit_s = count_d[4*i +: 4];
      end else begin
        digit_s = digit_s;
      end
      if ((IW'(i) >= idx_d) && (count_d[4*i +: 4] != 4'd0)) begin
        hi_nonzero_s = 1'b1;
      end else begin
        hi_nonzero_s = hi_nonzero_s;
      end
      an_d[i] = (idx_d != IW'(i));
    end
    lz_s        = blank_lz && (idx_d != {IW{1'b0}}) && !hi_nonzero_s;
    blink_off_s = (state_d == S_EXPIRED) && (presc_d >= PRESC_HALF);
    if (lz_s || blink_off_s) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = seg_enc(digit_s);
    end
  end

  // State and registered outputs.
  always_ff @(posedge orig_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      count_q   <= {CW{1'b0}};
      presc_q   <= {TW{1'b0}};
      scan_q    <= {SW{1'b0}};
      idx_q     <= {IW{1'b0}};
      seg_q     <= SEG_BLANK;
      an_q      <= {{(DIGITS-1){1'b1}}, 1'b0};
      tick_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      tick_q    <= tick_d;
      expired_q <= (state_d == S_EXPIRED);
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign tick    = tick_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_countdown_scan_display.sv
// Bench for countdown_scan_display: vector table, directed corner sequences and
// random stimulus against a decimal-arithmetic reference model.
module tb_countdown_scan_display;

  localparam int DIGITS   = 3;
  localparam int TICK_DIV = 10;
  localparam int SCAN_DIV = 2;
  localparam int M_IDLE = 0, M_PAUSE = 1, M_RUN = 2, M_EXP = 3;

  logic        orig_clk = 1'b0;
  logic        reset    = 1'b1;
  logic        load     = 1'b0;
  logic [11:0] load_bcd = 12'h000;
  logic        run      = 1'b0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        tick, expired;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  countdown_scan_display #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .orig_clk(orig_clk), .reset(reset), .load(load), .load_bcd(load_bcd),
    .run(run), .blank_lz(blank_lz), .seg(seg), .an(an), .tick(tick), .expired(expired)
  );

  always #5 orig_clk = ~orig_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int clamp_val(input logic [11:0] v);
    int r, m, d;
    r = 0;
    m = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(v[4*i +: 4]);
      r = r + ((d > 9) ? 9 : d) * m;
      m = m * 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] disp(input int cnt, input int idx, input logic blz,
                                      input bit ex, input int presc);
    int p;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (ex && presc >= TICK_DIV / 2) return 7'b1111111;
    if (blz && idx > 0 && cnt < p) return 7'b1111111;
    return enc((cnt / p) % 10);
  endfunction

  // Reference model: count kept as a plain decimal integer.
  typedef struct {
    int   count;
    int   mode;
    int   presc;
    int   scan;
    int   idx;
    logic tick;
  } mstate_t;

  function automatic mstate_t model_step(input mstate_t s, input logic ld,
                                         input logic [11:0] bcd, input logic rn);
    mstate_t n;
    n      = s;
    n.tick = 1'b0;
    if (ld) begin
      n.count = clamp_val(bcd);
      n.presc = 0;
      n.mode  = (n.count == 0) ? M_EXP : M_PAUSE;
    end else if (s.mode == M_PAUSE || s.mode == M_RUN) begin
      if (rn) begin
        n.mode = M_RUN;
        if (s.presc == TICK_DIV - 1) begin
          n.presc = 0;
          n.count = s.count - 1;
          n.tick  = 1'b1;
          if (n.count == 0) n.mode = M_EXP;
        end else begin
          n.presc = s.presc + 1;
        end
      end else begin
        n.mode = M_PAUSE;
      end
    end else if (s.mode == M_EXP) begin
      n.presc = (s.presc + 1) % TICK_DIV;
    end
    n.scan = s.scan + 1;
    if (n.scan == SCAN_DIV) begin
      n.scan = 0;
      n.idx  = (s.idx + 1) % DIGITS;
    end
    return n;
  endfunction

  function automatic logic [11:0] exp_out(input mstate_t s, input logic blz, input bit fresh);
    logic [2:0] a;
    if (fresh) return {1'b0, 1'b0, 3'b110, 7'b1111111};
    a        = 3'b111;
    a[s.idx] = 1'b0;
    return {s.tick, (s.mode == M_EXP), a, disp(s.count, s.idx, blz, s.mode == M_EXP, s.presc)};
  endfunction

  mstate_t m;
  logic    m_blz;
  bit      m_fresh;

  // Reference model state update.
  always @(posedge orig_clk or negedge reset) begin
    if (!reset) begin
      m       <= '{0, M_IDLE, 0, 0, 0, 1'b0};
      m_blz   <= 1'b0;
      m_fresh <= 1'b1;
    end else begin
      m       <= model_step(m, load, load_bcd, run);
      m_blz   <= blank_lz;
      m_fresh <= 1'b0;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge orig_clk) begin
    if (chk_en) chk("cycle_outputs", {20'd0, tick, expired, an, seg}, {20'd0, exp_out(m, m_blz, m_fresh)});
  end

  typedef struct {
    logic [11:0] bcd;
    logic        run_en;
    int          cycles;
    int          exp_ticks;
    logic        exp_expired;
    logic [11:0] exp_count;
  } row_t;

  row_t       rows [8];
  logic [6:0] cap  [0:2];

  task automatic apply_load(input logic [11:0] bcd, input logic r);
    @(negedge orig_clk);
    load     = 1'b1;
    load_bcd = bcd;
    run      = r;
    @(negedge orig_clk);
    load     = 1'b0;
  endtask

  task automatic capture();
    for (int j = 0; j < DIGITS; j++) cap[j] = 7'bxxxxxxx;
    for (int k = 0; k < 2 * DIGITS * SCAN_DIV; k++) begin
      @(negedge orig_clk);
      for (int j = 0; j < DIGITS; j++) if (an[j] == 1'b0) cap[j] = seg;
    end
  endtask

  initial begin
    int          nt, n;
    bit          found;
    logic [11:0] ec;

    rows[0] = '{12'h102, 1'b1, 40, 4, 1'b0, 12'h098};
    rows[1] = '{12'h002, 1'b1, 40, 2, 1'b1, 12'h000};
    rows[2] = '{12'h000, 1'b0,  5, 0, 1'b1, 12'h000};
    rows[3] = '{12'hA5F, 1'b0,  5, 0, 1'b0, 12'h959};
    rows[4] = '{12'h001, 1'b1, 10, 1, 1'b1, 12'h000};
    rows[5] = '{12'h0FA, 1'b0,  5, 0, 1'b0, 12'h099};
    rows[6] = '{12'h010, 1'b1, 20, 2, 1'b0, 12'h008};
    rows[7] = '{12'h999, 1'b1, 15, 1, 1'b0, 12'h998};

    #1 reset = 1'b0;
    repeat (3) @(negedge orig_clk);
    #2 reset = 1'b1;
    #1;
    chk("reset_an", {29'd0, an}, {29'd0, 3'b110});
    chk("reset_seg", {25'd0, seg}, {25'd0, 7'b1111111});
    chk("reset_expired", {31'd0, expired}, 32'd0);
    chk("reset_tick", {31'd0, tick}, 32'd0);
    chk_en = 1'b1;

    // IDLE ignores run
    run = 1'b1;
    nt  = 0;
    repeat (25) begin @(negedge orig_clk); if (tick) nt++; end
    chk("idle_ticks", nt, 0);

    for (int r = 0; r < 8; r++) begin
      blank_lz = 1'b0;
      apply_load(rows[r].bcd, rows[r].run_en);
      nt = 0;
      repeat (rows[r].cycles) begin @(negedge orig_clk); if (tick) nt++; end
      chk($sformatf("row%0d_ticks", r), nt, rows[r].exp_ticks);
      chk($sformatf("row%0d_expired", r), {31'd0, expired}, {31'd0, rows[r].exp_expired});
      run = 1'b0;
      if (!rows[r].exp_expired) begin
        capture();
        ec = rows[r].exp_count;
        for (int j = 0; j < DIGITS; j++)
          chk($sformatf("row%0d_digit%0d", r, j), {25'd0, cap[j]}, {25'd0, enc(int'(ec[4*j +: 4]))});
      end
    end

    // Leading-zero blanking
    blank_lz = 1'b1;
    apply_load(12'h099, 1'b0);
    capture();
    chk("blz099_d2", {25'd0, cap[2]}, {25'd0, 7'b1111111});
    chk("blz099_d1", {25'd0, cap[1]}, {25'd0, 7'b0010000});
    chk("blz099_d0", {25'd0, cap[0]}, {25'd0, 7'b0010000});
    apply_load(12'h005, 1'b0);
    capture();
    chk("blz005_d1", {25'd0, cap[1]}, {25'd0, 7'b1111111});
    chk("blz005_d0", {25'd0, cap[0]}, {25'd0, 7'b0010010});
    blank_lz = 1'b0;

    // Expiry with final tick, then blink 5 on / 5 off
    apply_load(12'h002, 1'b1);
    n = 0;
    while (!expired && n < 40) begin @(negedge orig_clk); n++; end
    chk("expire_latency", n, 20);
    chk("final_tick", {31'd0, tick}, 32'd1);
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin
        @(negedge orig_clk);
        chk($sformatf("blink_tick%0d", k), {31'd0, tick}, 32'd0);
      end
      chk($sformatf("blink_seg%0d", k), {25'd0, seg},
          {25'd0, ((k % 10) < 5) ? 7'b1000000 : 7'b1111111});
    end

    // Pause at prescaler 6 keeps the partial second
    apply_load(12'h500, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge orig_clk);
      if (m.mode == M_RUN && m.presc == 6) found = 1'b1;
    end
    chk("pause_found", {31'd0, found}, 32'd1);
    run = 1'b0;
    nt  = 0;
    repeat (20) begin @(negedge orig_clk); if (tick) nt++; end
    chk("pause_ticks", nt, 0);
    run = 1'b1;
    n   = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge orig_clk);
      n++;
      if (tick) break;
    end
    chk("resume_latency", n, 4);

    // Load coincident with prescaler wrap
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge orig_clk);
      if (m.mode == M_RUN && m.presc == TICK_DIV - 1) found = 1'b1;
    end
    chk("wrap_found", {31'd0, found}, 32'd1);
    load     = 1'b1;
    load_bcd = 12'h321;
    @(negedge orig_clk);
    load = 1'b0;
    chk("wrap_load_tick", {31'd0, tick}, 32'd0);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge orig_clk);
      n++;
      if (tick) break;
    end
    chk("wrap_load_next_tick", n, 10);
    run = 1'b0;
    capture();
    chk("wrap_load_d2", {25'd0, cap[2]}, {25'd0, enc(3)});
    chk("wrap_load_d1", {25'd0, cap[1]}, {25'd0, enc(2)});
    chk("wrap_load_d0", {25'd0, cap[0]}, {25'd0, enc(0)});

    // Asynchronous reset truncates a tick pulse
    apply_load(12'h005, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge orig_clk);
      if (tick) found = 1'b1;
    end
    chk("mid_tick_found", {31'd0, found}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_reset_tick", {31'd0, tick}, 32'd0);
    chk("mid_reset_an", {29'd0, an}, {29'd0, 3'b110});
    chk("mid_reset_seg", {25'd0, seg}, {25'd0, 7'b1111111});
    @(negedge orig_clk);
    #2 reset = 1'b1;

    // Random stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      @(negedge orig_clk);
      load = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 2) == 0) load_bcd = 12'($urandom_range(0, 3));
      else load_bcd = 12'($urandom);
      if ($urandom_range(0, 15) == 0) run = ~run;
      if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
    end
    @(negedge orig_clk);
    load = 1'b0;
    @(negedge orig_clk);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
